// File: rtl/iob_2p_mem_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for iob_2p_mem_fifo_ctrl.
//   push, pop  : write / read requests from the surrounding logic
//   full, empty: registered occupancy flags
//   level      : current occupancy, 0 .. 2**ADDR_W
//   pop_valid  : memory data_out carries the popped word this cycle
// The master modport is the side that issues requests. The slave modport is the controller.
interface iob_2p_mem_fifo_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              pop_valid;

    modport master (
        output push, pop,
        input  full, empty, level, pop_valid
    );

    modport slave (
        input  push, pop,
        output full, empty, level, pop_valid
    );
endinterface

// File: rtl/iob_2p_mem_fifo_ctrl.sv
// iob_2p_mem_fifo_ctrl: FIFO sequencer for one iob_2p_mem instance.
// The block owns the write/read pointers, the occupancy level and the flags.
// It drives the memory's write and read enables and addresses. Data goes
// from the producer straight to the memory data_in. It comes back from the
// memory data_out, one cycle after an accepted pop, with pop_valid high.
//
// Ports:
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   fifo (slave)       : push/pop requests; full/empty/level/pop_valid status
//   mem_w_en/mem_w_addr: memory write enable / address
//   mem_r_en/mem_r_addr: memory read enable / address
//   overflow/underflow : sticky error flags. They exist only when
//                        IOB_FIFO_CTRL_ERR_EN is defined.
//
// Optional feature macro: IOB_FIFO_CTRL_ERR_EN
module iob_2p_mem_fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    iob_2p_mem_fifo_ctrl_if.slave fifo,
`ifdef IOB_FIFO_CTRL_ERR_EN
    output logic                 overflow,
    output logic                 underflow,
`endif
    output logic                 mem_w_en,
    output logic [ADDR_W-1:0]    mem_w_addr,
    output logic                 mem_r_en,
    output logic [ADDR_W-1:0]    mem_r_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    // The controller never touches data. The word width only has to be legal.
    if (DATA_W < 1) begin : g_bad_data_w
        $error("iob_2p_mem_fifo_ctrl: DATA_W must be at least 1");
    end

    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   level_r;
    logic              pop_valid_r;
    logic              full_c;
    logic              empty_c;
    logic              push_acc;
    logic              pop_acc;

    assign full_c  = (level_r == DEPTH[ADDR_W:0]);
    assign empty_c = (level_r == '0);

    // Full blocks the push, so a push and a pop together on a full FIFO
    // degrade to a pop. Empty blocks the pop, so the same pair on an empty
    // FIFO degrades to a push. There is no bypass path.
    assign push_acc = fifo.push & ~full_c;
    assign pop_acc  = fifo.pop  & ~empty_c;

    assign mem_w_en   = push_acc & ~rst;
    assign mem_w_addr = w_ptr;
    assign mem_r_en   = pop_acc & ~rst;
    assign mem_r_addr = r_ptr;

    assign fifo.full      = full_c;
    assign fifo.empty     = empty_c;
    assign fifo.level     = level_r;
    assign fifo.pop_valid = pop_valid_r;

    // Pointer and occupancy state. Pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            level_r     <= '0;
            pop_valid_r <= 1'b0;
        end else begin
            if (push_acc) w_ptr <= w_ptr + 1'b1;
            if (pop_acc)  r_ptr <= r_ptr + 1'b1;
            if (push_acc && !pop_acc)
                level_r <= level_r + 1'b1;
            else if (pop_acc && !push_acc)
                level_r <= level_r - 1'b1;
            // Memory read latency is one cycle. data_out is valid one cycle after the pop.
            pop_valid_r <= pop_acc;
        end
    end

`ifdef IOB_FIFO_CTRL_ERR_EN
    // The flags stick until reset so that software can read them later.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo.push & full_c)  overflow  <= 1'b1;
            if (fifo.pop  & empty_c) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_iob_2p_mem_fifo_ctrl.sv
// Scoreboard bench for iob_2p_mem_fifo_ctrl with a behavioural two-port memory.
module tb_iob_2p_mem_fifo_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_2p_mem_fifo_ctrl_if #(.ADDR_W(ADDR_W)) fifo_if ();

    logic              mem_w_en, mem_r_en;
    logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef IOB_FIFO_CTRL_ERR_EN
    logic overflow, underflow;
`endif

    iob_2p_mem_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo       (fifo_if),
`ifdef IOB_FIFO_CTRL_ERR_EN
        .overflow   (overflow),
        .underflow  (underflow),
`endif
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr)
    );

    // iob_2p_mem stand-in: registered read with one-cycle latency
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= data_in;
        if (mem_r_en) data_out <= mem[mem_r_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int               m_level = 0;
    int               m_wp = 0;
    int               m_rp = 0;
    bit               m_pv = 0;
    bit               m_ov = 0;
    bit               m_un = 0;
    logic [DATA_W-1:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_status();
        check_eq("level", 32'(fifo_if.level), m_level);
        check_eq("full", 32'(fifo_if.full), (m_level == DEPTH));
        check_eq("empty", 32'(fifo_if.empty), (m_level == 0));
        check_eq("pop_valid", 32'(fifo_if.pop_valid), 32'(m_pv));
`ifdef IOB_FIFO_CTRL_ERR_EN
        check_eq("overflow", 32'(overflow), 32'(m_ov));
        check_eq("underflow", 32'(underflow), 32'(m_un));
`endif
        if (m_pv) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", 32'(1), 32'(0));
            end else begin
                check_eq("data_out", 32'(data_out), 32'(sb.pop_front()));
            end
        end
    endtask

    // One clock of stimulus with model prediction and checking
    task automatic step(input bit p, input bit q, input logic [DATA_W-1:0] d);
        bit wacc, racc;
        @(negedge clk);
        fifo_if.push = p;
        fifo_if.pop  = q;
        data_in      = d;
        #1;
        wacc = p && (m_level != DEPTH);
        racc = q && (m_level != 0);
        check_eq("w_en", 32'(mem_w_en), 32'(wacc));
        check_eq("r_en", 32'(mem_r_en), 32'(racc));
        if (wacc) check_eq("w_addr", 32'(mem_w_addr), m_wp);
        if (racc) check_eq("r_addr", 32'(mem_r_addr), m_rp);
        @(posedge clk);
        if (p && m_level == DEPTH) m_ov = 1;
        if (q && m_level == 0)     m_un = 1;
        if (wacc) begin
            sb.push_back(d);
            m_wp = (m_wp + 1) % DEPTH;
        end
        if (racc) m_rp = (m_rp + 1) % DEPTH;
        m_level = m_level + int'(wacc) - int'(racc);
        m_pv = racc;
        #1;
        check_status();
    endtask

    task automatic do_reset(input int n, input bit p, input bit q);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            fifo_if.push = p;
            fifo_if.pop  = q;
            #1;
            check_eq("rst_w_en", 32'(mem_w_en), 32'(0));
            check_eq("rst_r_en", 32'(mem_r_en), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        fifo_if.push = 1'b0;
        fifo_if.pop  = 1'b0;
        m_level = 0; m_wp = 0; m_rp = 0; m_pv = 0; m_ov = 0; m_un = 0;
        sb.delete();
        #1;
        check_status();
    endtask

    initial begin
        fifo_if.push = 1'b0;
        fifo_if.pop  = 1'b0;
        data_in      = '0;

        // Reset with a push request pending: the enables must stay low.
        do_reset(2, 1'b1, 1'b0);

        // Fill with 32..47, then drain
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(32 + i));
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Wrap-around: 12/12, then 8/8 crossing address 15 -> 0
        for (int i = 0; i < 12; i++) step(1, 0, 8'(8'h60 + i));
        for (int i = 0; i < 12; i++) step(0, 1, 8'h00);
        for (int i = 0; i < 8; i++)  step(1, 0, 8'(8'h80 + i));
        for (int i = 0; i < 8; i++)  step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Push and pop together at level 5
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h20 + i));
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Push and pop together when empty: only the push is taken
        step(1, 1, 8'h3C);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Push and pop together when full: only the pop is taken
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom_range(0, 255)));
        step(1, 0, 8'hEE);  // overflow attempt while full
        step(1, 1, 8'hEF);
        step(1, 0, 8'h77);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
        step(0, 1, 8'h00);  // underflow attempt while empty
        step(0, 0, 8'h00);

        // Sticky flags survive normal traffic
        step(1, 0, 8'h01);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Reset mid-operation with a pending pop at level 7
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h40 + i));
        step(0, 1, 8'h00);  // this pop is accepted just before reset
        do_reset(1, 1'b0, 1'b1);
        step(1, 0, 8'hA5);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Random traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
